hsv_axil_ram: RTL and testbench

AXI-lite responder (slave) backing a word-organized RAM. It is the far end of the dmem master port driven by the core's memory unit, used as data memory in simulation and small SoC builds. It accepts AR/AW/W independently, applies byte strobes, and returns R/B responses with single-outstanding-transaction ordering. Out-of-window accesses return SLVERR.

---
 rtl/hsv_axil_ram.sv | 197 +++++++++++++++++++
 tb/tb_hsv_axil_ram.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hsv_axil_ram.sv
// AXI-lite responder backed by a word-organised RAM with byte strobes; out-of-window accesses get SLVERR.
// Optional build macro HSV_AXIL_RAM_WAIT_EN adds LFSR-driven ready gating and response-launch delay.
module hsv_axil_ram #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk_core,
  input  logic        rst_core,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam logic [31:0] SPAN  = 32'(DEPTH * 4);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RRESP = 2'd1,
    BRESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        aw_full_q, aw_full_d;
  logic [31:0] aw_addr_q, aw_addr_d;
  logic        w_full_q, w_full_d;
  logic [31:0] w_data_q, w_data_d;
  logic [3:0]  w_strb_q, w_strb_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [1:0]  bresp_q, bresp_d;

  logic [31:0] mem [DEPTH];

  // Offsets are taken 33 bits wide so an address below BASE_ADDR shows up as a borrow, not a wrap.
  logic [32:0]      ar_off, aw_off;
  logic             ar_in_win, aw_in_win;
  logic [IDX_W-1:0] ar_idx, aw_idx;

  assign ar_off    = {1'b0, araddr} - {1'b0, BASE_ADDR};
  assign aw_off    = {1'b0, aw_addr_q} - {1'b0, BASE_ADDR};
  assign ar_in_win = ~ar_off[32] & (ar_off[31:0] < SPAN);
  assign aw_in_win = ~aw_off[32] & (aw_off[31:0] < SPAN);
  assign ar_idx    = ar_off[IDX_W+1:2];
  assign aw_idx    = aw_off[IDX_W+1:2];

  logic ready_gate;
  logic idle_free;

`ifdef HSV_AXIL_RAM_WAIT_EN
  logic [7:0] lfsr_q, lfsr_d;
  state_e     pend_q, pend_d;
  logic       launch_ok;

  assign ready_gate = ~lfsr_q[0];
  assign launch_ok  = ~lfsr_q[1];
  assign idle_free  = (state_q == IDLE) & (pend_q == IDLE);
`else
  assign ready_gate = 1'b1;
  assign idle_free  = (state_q == IDLE);
`endif

  logic aw_hs, w_hs, rd_fire, wr_fire;

  assign awready = ~rst_core & ready_gate & ~aw_full_q;
  assign wready  = ~rst_core & ready_gate & ~w_full_q;
  assign arready = ~rst_core & ready_gate & idle_free & ~aw_full_q & ~w_full_q;

  assign aw_hs   = awvalid & awready;
  assign w_hs    = wvalid & wready;
  assign rd_fire = arvalid & arready;
  // A complete AW/W pair wins over a read: arready is already low whenever either buffer is full.
  assign wr_fire = idle_free & aw_full_q & w_full_q;

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through this block can infer a latch.
    state_d   = state_q;
    aw_full_d = aw_full_q;
    aw_addr_d = aw_addr_q;
    w_full_d  = w_full_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    bresp_d   = bresp_q;
`ifdef HSV_AXIL_RAM_WAIT_EN
    pend_d    = pend_q;
    lfsr_d    = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
`endif

    if (aw_hs) begin
      aw_full_d = 1'b1;
      aw_addr_d = awaddr;
    end
    if (w_hs) begin
      w_full_d = 1'b1;
      w_data_d = wdata;
      w_strb_d = wstrb;
    end

    if (wr_fire) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bresp_d   = aw_in_win ? RESP_OKAY : RESP_SLVERR;
    end

    if (rd_fire) begin
      rdata_d = ar_in_win ? mem[ar_idx] : 32'h0;
      rresp_d = ar_in_win ? RESP_OKAY : RESP_SLVERR;
    end

    unique case (state_q)
      IDLE: begin
`ifdef HSV_AXIL_RAM_WAIT_EN
        // Results are latched at acceptance; the response is only launched when the LFSR allows it.
        if (wr_fire)      pend_d = BRESP;
        else if (rd_fire) pend_d = RRESP;
        if ((pend_q != IDLE) && launch_ok) begin
          state_d = pend_q;
          pend_d  = IDLE;
        end
`else
        if (wr_fire)      state_d = BRESP;
        else if (rd_fire) state_d = RRESP;
`endif
      end
      RRESP:   if (rready) state_d = IDLE;
      BRESP:   if (bready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk_core or posedge rst_core) begin
    if (rst_core) begin
      state_q   <= IDLE;
      aw_full_q <= 1'b0;
      aw_addr_q <= 32'h0;
      w_full_q  <= 1'b0;
      w_data_q  <= 32'h0;
      w_strb_q  <= 4'h0;
      rdata_q   <= 32'h0;
      rresp_q   <= 2'b00;
      bresp_q   <= 2'b00;
`ifdef HSV_AXIL_RAM_WAIT_EN
      lfsr_q    <= 8'hA5;
      pend_q    <= IDLE;
`endif
    end else begin
      state_q   <= state_d;
      aw_full_q <= aw_full_d;
      aw_addr_q <= aw_addr_d;
      w_full_q  <= w_full_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      bresp_q   <= bresp_d;
`ifdef HSV_AXIL_RAM_WAIT_EN
      lfsr_q    <= lfsr_d;
      pend_q    <= pend_d;
`endif
    end
  end

  // NOTE: the RAM array has no reset; clearing it would turn it into a huge flop bank instead of a memory.
  always_ff @(posedge clk_core) begin
    if (wr_fire && aw_in_win) begin
      for (int i = 0; i < 4; i++) begin
        if (w_strb_q[i]) mem[aw_idx][8*i +: 8] <= w_data_q[8*i +: 8];
      end
    end
  end

  assign rvalid = (state_q == RRESP);
  assign bvalid = (state_q == BRESP);
  assign rdata  = rdata_q;
  assign rresp  = rresp_q;
  assign bresp  = bresp_q;

endmodule

// File: tb/tb_hsv_axil_ram.sv
// Self-checking bench for hsv_axil_ram: directed scenarios plus randomized traffic against an array model.
`timescale 1ns/1ps
module tb_hsv_axil_ram;

  localparam int unsigned DEPTH     = 1024;
  localparam logic [31:0] BASE_ADDR = 32'h0000_0000;

  logic        clk_core = 1'b0;
  logic        rst_core = 1'b1;
  logic [31:0] araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [31:0] awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;

  int errors = 0;
  int checks = 0;

  hsv_axil_ram #(.DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR)) dut (
    .clk_core(clk_core), .rst_core(rst_core),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk_core = ~clk_core;

  // Reference model: memory as a plain array of words plus a "has been fully written" flag.
  logic [31:0] ref_mem   [DEPTH];
  bit          ref_known [DEPTH];

  function automatic bit ref_in_window(input logic [31:0] a);
    longint unsigned lo, hi;
    lo = longint'(BASE_ADDR);
    hi = lo + longint'(DEPTH) * 4;
    return (longint'(a) >= lo) && (longint'(a) < hi);
  endfunction

  function automatic int ref_word(input logic [31:0] a);
    return int'((longint'(a) - longint'(BASE_ADDR)) / 4);
  endfunction

  function automatic logic [1:0] ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int w;
    if (!ref_in_window(a)) return 2'b10;
    w = ref_word(a);
    for (int b = 0; b < 4; b++) if (s[b]) ref_mem[w][8*b +: 8] = d[8*b +: 8];
    if (s == 4'hF) ref_known[w] = 1'b1;
    return 2'b00;
  endfunction

  task automatic ref_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r, output bit known);
    if (!ref_in_window(a)) begin
      d = 32'h0; r = 2'b10; known = 1'b1;
    end else begin
      d = ref_mem[ref_word(a)]; r = 2'b00; known = ref_known[ref_word(a)];
    end
  endtask

  task automatic tick();
    @(posedge clk_core);
    #1;
  endtask

  // Drives one AW/W pair; w_lead > 0 offers W that many cycles before AW, < 0 offers AW first.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int w_lead, output logic [1:0] resp, output int lat);
    bit aw_done, w_done, aw_hs, w_hs;
    int c, aw_start, w_start;
    aw_done = 0; w_done = 0; c = 0;
    aw_start = (w_lead > 0) ? w_lead : 0;
    w_start  = (w_lead < 0) ? -w_lead : 0;
    awaddr = a; wdata = d; wstrb = s;
    while (!(aw_done && w_done) && c < 200) begin
      awvalid = !aw_done && (c >= aw_start);
      wvalid  = !w_done && (c >= w_start);
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      tick();
      if (aw_hs) aw_done = 1;
      if (w_hs)  w_done = 1;
      c++;
    end
    awvalid = 0; wvalid = 0;
    lat = 0;
    while (!bvalid && lat < 200) begin tick(); lat++; end
    if (!bvalid) begin
      checks++; errors++;
      $display("FAIL write_timeout: addr=%h no bvalid within bound", a);
      resp = 2'bxx; lat = -1;
      return;
    end
    resp = bresp;
    bready = 1; tick(); bready = 0;
  endtask

  // One read; rready is held low for 'hold' cycles, and stable=0 if anything moved meanwhile.
  task automatic do_read(input logic [31:0] a, input int hold, output logic [31:0] d,
                         output logic [1:0] r, output int lat, output bit stable);
    int c;
    c = 0; stable = 1;
    araddr = a; arvalid = 1;
    while (!arready && c < 200) begin tick(); c++; end
    if (!arready) begin
      checks++; errors++;
      $display("FAIL read_accept_timeout: addr=%h arready never high", a);
      arvalid = 0; d = 'x; r = 'x; lat = -1;
      return;
    end
    tick(); arvalid = 0;
    lat = 0;
    while (!rvalid && lat < 200) begin tick(); lat++; end
    if (!rvalid) begin
      checks++; errors++;
      $display("FAIL read_timeout: addr=%h no rvalid within bound", a);
      d = 'x; r = 'x; lat = -1;
      return;
    end
    d = rdata; r = rresp;
    for (int k = 0; k < hold; k++) begin
      tick();
      if (!rvalid || rdata !== d || rresp !== r || arready !== 1'b0) stable = 0;
    end
    rready = 1; tick(); rready = 0;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++;
    if ({arready, awready, wready, rvalid, bvalid} !== 5'b0) begin
      errors++;
      $display("FAIL reset_handshake: got ar/aw/w/r/b=%b expected 00000", {arready, awready, wready, rvalid, bvalid});
    end
    checks++;
    if ({rdata, rresp, bresp} !== 36'h0) begin
      errors++;
      $display("FAIL reset_regs: got rdata=%h rresp=%b bresp=%b expected zeros", rdata, rresp, bresp);
    end
    rst_core = 0;
    tick();
    checks++;
    if ({arready, awready, wready} !== 3'b111) begin
      errors++;
      $display("FAIL post_reset_ready: got %b expected 111", {arready, awready, wready});
    end
  endtask

  task automatic test_basic();
    logic [1:0] br, rr; logic [31:0] d; int lat; bit st;
    void'(ref_write(32'h10, 32'hDEAD_BEEF, 4'hF));
    do_write(32'h10, 32'hDEAD_BEEF, 4'hF, 0, br, lat);
    checks++;
    if (br !== 2'b00 || lat !== 1) begin
      errors++;
      $display("FAIL basic_write: got bresp=%b lat=%0d expected 00 lat=1", br, lat);
    end
    do_read(32'h10, 0, d, rr, lat, st);
    checks++;
    if (d !== 32'hDEAD_BEEF || rr !== 2'b00 || lat !== 0) begin
      errors++;
      $display("FAIL basic_read: got %h/%b lat=%0d expected deadbeef/00 lat=0", d, rr, lat);
    end
  endtask

  task automatic test_w_first_strobe();
    logic [1:0] br, rr; logic [31:0] d; int lat; bit st;
    void'(ref_write(32'h10, 32'h1122_3344, 4'b0101));
    do_write(32'h10, 32'h1122_3344, 4'b0101, 3, br, lat);
    checks++;
    if (br !== 2'b00 || lat !== 1) begin
      errors++;
      $display("FAIL w_first_write: got bresp=%b lat=%0d expected 00 lat=1", br, lat);
    end
    do_read(32'h13, 0, d, rr, lat, st);
    checks++;
    if (d !== 32'hDE22_BE44 || rr !== 2'b00) begin
      errors++;
      $display("FAIL strobe_merge: got %h/%b expected de22be44/00", d, rr);
    end
  endtask

  task automatic test_window();
    logic [1:0] br, rr; logic [31:0] d; int lat; bit st;
    void'(ref_write(32'h0, 32'hCAFE_0000, 4'hF));
    do_write(32'h0, 32'hCAFE_0000, 4'hF, -2, br, lat);
    void'(ref_write(32'hFFC, 32'h5A5A_A5A5, 4'hF));
    do_write(32'hFFC, 32'h5A5A_A5A5, 4'hF, 0, br, lat);
    checks++;
    if (br !== 2'b00) begin
      errors++;
      $display("FAIL last_word_write: got bresp=%b expected 00", br);
    end
    do_read(32'h1000, 0, d, rr, lat, st);
    checks++;
    if (d !== 32'h0 || rr !== 2'b10) begin
      errors++;
      $display("FAIL oow_read: got %h/%b expected 00000000/10", d, rr);
    end
    do_write(32'h1000, 32'hBAD0_BAD0, 4'hF, 0, br, lat);
    checks++;
    if (br !== 2'b10) begin
      errors++;
      $display("FAIL oow_write: got bresp=%b expected 10", br);
    end
    do_read(32'h0, 0, d, rr, lat, st);
    checks++;
    if (d !== 32'hCAFE_0000 || rr !== 2'b00) begin
      errors++;
      $display("FAIL oow_no_alias: got %h/%b expected cafe0000/00", d, rr);
    end
    do_read(32'hFFC, 0, d, rr, lat, st);
    checks++;
    if (d !== 32'h5A5A_A5A5 || rr !== 2'b00) begin
      errors++;
      $display("FAIL last_word_read: got %h/%b expected 5a5aa5a5/00", d, rr);
    end
  endtask

  task automatic test_backpressure();
    logic [1:0] rr; logic [31:0] d; int lat; bit st;
    do_read(32'h10, 5, d, rr, lat, st);
    checks++;
    if (st !== 1'b1 || d !== 32'hDE22_BE44) begin
      errors++;
      $display("FAIL r_stall_stable: got stable=%b data=%h expected 1/de22be44", st, d);
    end
    araddr = 32'h0; arvalid = 1;
    checks++;
    if (arready !== 1'b1) begin
      errors++;
      $display("FAIL ar_after_r: got arready=%b expected 1", arready);
    end
    tick(); arvalid = 0;
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'hCAFE_0000) begin
      errors++;
      $display("FAIL ar_after_r_data: got rvalid=%b rdata=%h expected 1/cafe0000", rvalid, rdata);
    end
    rready = 1; tick(); rready = 0;
  endtask

  task automatic test_write_priority();
    araddr = 32'h0; arvalid = 1;
    tick(); arvalid = 0;
    awaddr = 32'h0; wdata = 32'h600D_F00D; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    tick(); awvalid = 0; wvalid = 0;
    void'(ref_write(32'h0, 32'h600D_F00D, 4'hF));
    araddr = 32'h0; arvalid = 1; rready = 1;
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'hCAFE_0000 || arready !== 1'b0) begin
      errors++;
      $display("FAIL prio_first_read: got rvalid=%b rdata=%h arready=%b expected 1/cafe0000/0", rvalid, rdata, arready);
    end
    tick(); rready = 0;
    checks++;
    if (arready !== 1'b0 || rvalid !== 1'b0) begin
      errors++;
      $display("FAIL prio_ar_blocked: got arready=%b rvalid=%b expected 0/0", arready, rvalid);
    end
    tick();
    checks++;
    if (bvalid !== 1'b1 || bresp !== 2'b00 || rvalid !== 1'b0) begin
      errors++;
      $display("FAIL prio_write_first: got bvalid=%b bresp=%b rvalid=%b expected 1/00/0", bvalid, bresp, rvalid);
    end
    bready = 1; tick(); bready = 0;
    checks++;
    if (arready !== 1'b1) begin
      errors++;
      $display("FAIL prio_ar_release: got arready=%b expected 1", arready);
    end
    tick(); arvalid = 0;
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'h600D_F00D) begin
      errors++;
      $display("FAIL prio_read_new: got rvalid=%b rdata=%h expected 1/600df00d", rvalid, rdata);
    end
    rready = 1; tick(); rready = 0;
  endtask

  task automatic test_reset_mid();
    logic [1:0] br, rr; logic [31:0] d; int lat; bit st;
    void'(ref_write(32'h20, 32'h0BAD_CAFE, 4'hF));
    do_write(32'h20, 32'h0BAD_CAFE, 4'hF, 0, br, lat);
    awaddr = 32'h20; awvalid = 1;
    tick(); awvalid = 0;
    checks++;
    if (arready !== 1'b0 || wready !== 1'b1 || awready !== 1'b0) begin
      errors++;
      $display("FAIL aw_only_buffered: got ar/aw/w=%b expected 001", {arready, awready, wready});
    end
    rst_core = 1;
    #1;
    checks++;
    if ({arready, awready, wready, rvalid, bvalid} !== 5'b0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got %b expected 00000", {arready, awready, wready, rvalid, bvalid});
    end
    tick(); tick();
    rst_core = 0;
    tick(); tick();
    checks++;
    if (rvalid !== 1'b0 || bvalid !== 1'b0 || arready !== 1'b1) begin
      errors++;
      $display("FAIL after_mid_reset: got rvalid=%b bvalid=%b arready=%b expected 0/0/1", rvalid, bvalid, arready);
    end
    do_read(32'h20, 0, d, rr, lat, st);
    checks++;
    if (d !== 32'h0BAD_CAFE || rr !== 2'b00) begin
      errors++;
      $display("FAIL mid_reset_no_write: got %h/%b expected 0badcafe/00", d, rr);
    end
  endtask

  task automatic test_random();
    logic [31:0] pool [12];
    logic [31:0] a, d, exp_d; logic [3:0] s; logic [1:0] r, exp_r;
    int lat, lead, hold; bit st, known;
    for (int i = 0; i < 9; i++) pool[i] = {20'h0, 10'($urandom_range(0, DEPTH - 1)), 2'b00};
    pool[9]  = 32'h0000_1000 + {20'h0, 10'($urandom), 2'b00};
    pool[10] = 32'hFFFF_FFFC;
    pool[11] = 32'h0000_0FFC;
    for (int i = 0; i < 12; i++) begin
      d = $urandom;
      exp_r = ref_write(pool[i], d, 4'hF);
      do_write(pool[i], d, 4'hF, 0, r, lat);
    end
    for (int n = 0; n < 40; n++) begin
      a = pool[$urandom_range(0, 11)] | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom; s = 4'($urandom);
        lead = $urandom_range(0, 6) - 3;
        exp_r = ref_write(a, d, s);
        do_write(a, d, s, lead, r, lat);
        checks++;
        if (r !== exp_r || lat !== 1) begin
          errors++;
          $display("FAIL rand_write[%0d]: addr=%h got bresp=%b lat=%0d expected %b lat=1", n, a, r, lat, exp_r);
        end
      end else begin
        hold = $urandom_range(0, 3);
        ref_read(a, exp_d, exp_r, known);
        do_read(a, hold, d, r, lat, st);
        checks++;
        if ((known && d !== exp_d) || r !== exp_r || lat !== 0 || !st) begin
          errors++;
          $display("FAIL rand_read[%0d]: addr=%h got %h/%b lat=%0d stable=%b expected %h/%b lat=0 stable=1",
                   n, a, d, r, lat, st, exp_d, exp_r);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_w_first_strobe();
    test_window();
    test_backpressure();
    test_write_priority();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time (errors=%0d)", errors);
    $fatal(1, "watchdog expired");
  end

endmodule
